reset_ctl: RTL and testbench
============================

# reset_ctl

Reset conditioner between the board reset sources and the P1V core. It synchronizes and filters the tactile key (KEY[0]) and the Prop plug reset pin, then produces a glitch-free, minimum-width, active-low reset for the `p1v` core's `inp_resn` input. It replaces the direct combinational AND of the two raw sources in the DE0-Nano top level. It also reports which source caused the last reset.

## Interface
- SYNC_STAGES, 2: synchronizer depth per raw input (≥2).
- DEBOUNCE_CYCLES, 1600000: consecutive stable samples needed to accept a key change (10 ms at 160 MHz).
- MIN_PULSE, 16: consecutive stable samples needed to accept a res_pin change.
- STRETCH_CYCLES, 16000000: reset hold time after all sources release (100 ms).
- clock_160  input  1  system clock; the only clock.
- res  input  1  synchronous, active-high reset (e.g. PLL not locked).
- key_n  input  1  raw KEY[0], active-low, asynchronous, bouncy.
- res_pin  input  1  raw Prop plug reset, active-low, asynchronous.
- resn  output  1  conditioned reset to `p1v` `inp_resn`, active-low, registered.
- cause  output  2  last reset source: 00 res/power-on, 01 key, 10 Prop plug, 11 both.

## Operation
- Synchronizers: each raw input passes through SYNC_STAGES flops. Reset value is 1 (deasserted).
- Key filter: the filtered level flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive samples. Any sample matching the filtered level clears the counter.
  - Counter width: $clog2(DEBOUNCE_CYCLES+1).
- Pin filter: same mechanism with threshold MIN_PULSE.
- req = key filtered low OR pin filtered low.
- FSM states:
  - S_STRETCH: resn=0, counter increments each cycle.
    - req → S_HOLD.
    - Counter reaches STRETCH_CYCLES-1 → S_RUN.
  - S_RUN: resn=1.
    - req → S_HOLD.
  - S_HOLD: resn=0.
    - req low → S_STRETCH, counter cleared.
- resn is a flop updated on the same edge as the state: resn = (next state == S_RUN).
- cause on entry to S_HOLD: loads {pin_req, key_req}.
  - While in S_HOLD, newly active sources are ORed in.
  - Otherwise cause is held.
- res (any state): state=S_STRETCH, counter=0, resn=0, cause=00, synchronizers=1, filters deasserted with counters cleared. res overrides all other inputs on the same edge.
- Reset values: resn=0, cause=00.

## Timing
- Edge counting: edge 1 is the first rising edge that samples the raw input at its new level.
- Key press to resn low: edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Pin low to resn low: edge SYNC_STAGES+MIN_PULSE+1.
- Release of the last active source to resn high: edge SYNC_STAGES+threshold+1+STRETCH_CYCLES, where threshold is that source's filter threshold.
- After res is sampled low, resn rises on edge STRETCH_CYCLES, provided no request is pending.
- A source asserting during S_STRETCH returns the FSM to S_HOLD. The stretch restarts in full on release.
- Simultaneous key and pin assertion gives cause=11.
- Key or pin pulses shorter than their threshold are never visible on resn.

## Configuration
- RES_PIN_FILTER_EN defined: the res_pin filter is present, with threshold MIN_PULSE.
- RES_PIN_FILTER_EN undefined: the synchronized res_pin drives pin_req directly (threshold 0).
  - Pin low to resn low becomes edge SYNC_STAGES+1.
  - MIN_PULSE is ignored.
- The key debounce is always present.

## Structure
- Package `reset_ctl_pkg` holds:
  - The state enum (S_STRETCH, S_RUN, S_HOLD).
  - The cause encodings CAUSE_POR, CAUSE_KEY, CAUSE_PIN, CAUSE_BOTH.
- Sub-module `reset_filter` implements one synchronizer plus consecutive-count filter.
  - Parameters: SYNC_STAGES, THRESHOLD.
  - Instantiated once for the key and once for the pin (the pin instance only when RES_PIN_FILTER_EN is defined).

## Test plan
Bench overrides: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, MIN_PULSE=4, STRETCH_CYCLES=20.
- Power-on: res high for 3 cycles, then low, inputs idle → resn=0 and cause=00 until edge 20, then resn=1.
- Key press held 30 cycles, released → resn falls at edge 11 and rises 2+8+1+20=31 edges after release; cause=01.
- Key bounce: key_n low 5 cycles, high 2 cycles, repeated 4 times → resn stays 1.
- Pin pulse of 3 cycles → no reset with RES_PIN_FILTER_EN; without it, resn falls at edge 3 and cause=10.
- Key and pin asserted on the same edge, both held 20 cycles → cause=11.
  - Release pin first, key 5 cycles later → stretch starts only after the key filter releases.
- res asserted mid-S_HOLD with key held → next edge resn=0, cause=00, FSM in S_STRETCH.
  - After res drops, the key re-debounces: S_HOLD is re-entered at edge 11 with cause=01.

Source files
------------

// File: rtl/reset_ctl_pkg.sv
// Shared types for the reset conditioner: FSM states and reset-cause encodings.
// No logic; imported by reset_filter and reset_ctl.
// Cause bit 1 = Prop plug pin, bit 0 = key, so the encodings can be ORed together.
package reset_ctl_pkg;

  typedef enum logic [1:0] {
    S_STRETCH = 2'd0,
    S_RUN     = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_KEY  = 2'b01;
  localparam logic [1:0] CAUSE_PIN  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/reset_filter.sv
// Synchronizer plus consecutive-count filter for one active-low raw reset source.
// Latency: SYNC_STAGES + THRESHOLD edges from raw change to level change.
// No backpressure; level only moves after THRESHOLD consecutive differing samples.
module reset_filter
  import reset_ctl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int THRESHOLD   = 16
) (
  input  logic clock_160,
  input  logic res,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(THRESHOLD + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   sync_q;

  assign sync_q = sync[SYNC_STAGES-1];

  always_ff @(posedge clock_160) begin
    if (res) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      // Any sample agreeing with the current level restarts the count.
      if (sync_q != level) begin
        if (cnt == CW'(THRESHOLD - 1)) begin
          level <= sync_q;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reset_ctl.sv
// Reset conditioner: filtered key/pin sources -> stretched, registered active-low resn for p1v.
// Latency: key SYNC+DEBOUNCE+1 edges to resn low; release adds STRETCH_CYCLES. Optional RES_PIN_FILTER_EN.
// No backpressure; any pending request holds resn low and restarts the stretch on release.
module reset_ctl
  import reset_ctl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1600000,
  parameter int MIN_PULSE       = 16,
  parameter int STRETCH_CYCLES  = 16000000
) (
  input  logic       clock_160,
  input  logic       res,
  input  logic       key_n,
  input  logic       res_pin,
  output logic       resn,
  output logic [1:0] cause
);

  localparam int SCW = $clog2(STRETCH_CYCLES + 1);

  logic key_level;
  logic key_req;
  logic pin_req;
  logic req;

  reset_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .THRESHOLD   (DEBOUNCE_CYCLES)
  ) u_key_filter (
    .clock_160 (clock_160),
    .res       (res),
    .raw       (key_n),
    .level     (key_level)
  );

  assign key_req = ~key_level;

`ifdef RES_PIN_FILTER_EN
  logic pin_level;

  reset_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .THRESHOLD   (MIN_PULSE)
  ) u_pin_filter (
    .clock_160 (clock_160),
    .res       (res),
    .raw       (res_pin),
    .level     (pin_level)
  );

  assign pin_req = ~pin_level;
`else
  // Unfiltered pin: the synchronizer output drives the request directly.
  localparam int unused_min_pulse = MIN_PULSE;

  logic [SYNC_STAGES-1:0] pin_sync;

  always_ff @(posedge clock_160) begin
    if (res) begin
      pin_sync <= '1;
    end else begin
      pin_sync <= {pin_sync[SYNC_STAGES-2:0], res_pin};
    end
  end

  assign pin_req = ~pin_sync[SYNC_STAGES-1];
`endif

  assign req = key_req | pin_req;

  state_t         state;
  state_t         state_nxt;
  logic [SCW-1:0] cnt;
  logic [SCW-1:0] cnt_nxt;
  logic [1:0]     cause_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    cause_nxt = cause;

    case (state)
      S_STRETCH: begin
        if (req) begin
          state_nxt = S_HOLD;
        end else if (cnt == SCW'(STRETCH_CYCLES - 1)) begin
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (req) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!req) begin
          state_nxt = S_STRETCH;
        end
      end
      default: begin
        state_nxt = S_STRETCH;
      end
    endcase

    // Entry to hold records the active sources; staying in hold accumulates late ones.
    if (state_nxt == S_HOLD) begin
      if (state != S_HOLD) begin
        cause_nxt = {pin_req, key_req};
      end else begin
        cause_nxt = cause | {pin_req, key_req};
      end
    end
  end

  always_ff @(posedge clock_160) begin
    if (res) begin
      state <= S_STRETCH;
      cnt   <= '0;
      resn  <= 1'b0;
      cause <= CAUSE_POR;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      resn  <= (state_nxt == S_RUN);
      cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_reset_ctl.sv
// Directed bench for reset_ctl with small timing parameters; hand-computed edge counts.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_reset_ctl;

  logic       clock_160;
  logic       res;
  logic       key_n;
  logic       res_pin;
  logic       resn;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;
  logic saw_low;

  reset_ctl #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .MIN_PULSE       (4),
    .STRETCH_CYCLES  (20)
  ) dut (
    .clock_160 (clock_160),
    .res       (res),
    .key_n     (key_n),
    .res_pin   (res_pin),
    .resn      (resn),
    .cause     (cause)
  );

  initial clock_160 = 1'b0;
  always #5 clock_160 = ~clock_160;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_160);
      #1;
    end
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_160);
      #1;
      if (resn !== 1'b1) saw_low = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    res     = 1'b1;
    key_n   = 1'b1;
    res_pin = 1'b1;

    // Power-on: 3 cycles of res, then stretch of 20 edges.
    tick(3);
    check("reset_resn", {1'b0, resn}, 2'b00);
    check("reset_cause", cause, 2'b00);
    res = 1'b0;
    tick(19);
    check("por_resn_edge19", {1'b0, resn}, 2'b00);
    check("por_cause_edge19", cause, 2'b00);
    tick(1);
    check("por_resn_edge20", {1'b0, resn}, 2'b01);

    // Key held 30 cycles: resn falls at edge 11, rises 31 edges after release.
    key_n = 1'b0;
    tick(10);
    check("key_resn_edge10", {1'b0, resn}, 2'b01);
    tick(1);
    check("key_resn_edge11", {1'b0, resn}, 2'b00);
    check("key_cause", cause, 2'b01);
    tick(19);
    key_n = 1'b1;
    tick(30);
    check("key_rel_edge30", {1'b0, resn}, 2'b00);
    tick(1);
    check("key_rel_edge31", {1'b0, resn}, 2'b01);
    check("key_cause_held", cause, 2'b01);

    // Key bounce: 5 low / 2 high, four times; never reaches the debounce count.
    saw_low = 1'b0;
    for (int r = 0; r < 4; r++) begin
      key_n = 1'b0;
      watch(5);
      key_n = 1'b1;
      watch(2);
    end
    watch(12);
    check("bounce_no_reset", {1'b0, saw_low}, 2'b00);

    // Pin pulse of 3 cycles.
    res_pin = 1'b0;
`ifdef RES_PIN_FILTER_EN
    saw_low = 1'b0;
    watch(3);
    res_pin = 1'b1;
    watch(30);
    check("pin_pulse_filtered", {1'b0, saw_low}, 2'b00);
    check("pin_pulse_cause", cause, 2'b01);
`else
    tick(2);
    check("pin_resn_edge2", {1'b0, resn}, 2'b01);
    tick(1);
    check("pin_resn_edge3", {1'b0, resn}, 2'b00);
    check("pin_cause", cause, 2'b10);
    res_pin = 1'b1;
    tick(22);
    check("pin_rel_edge22", {1'b0, resn}, 2'b00);
    tick(1);
    check("pin_rel_edge23", {1'b0, resn}, 2'b01);
`endif

    // Key and pin together for 20 cycles, pin released 5 cycles before key.
    key_n   = 1'b0;
    res_pin = 1'b0;
    tick(20);
    check("both_resn", {1'b0, resn}, 2'b00);
    check("both_cause", cause, 2'b11);
    res_pin = 1'b1;
    tick(5);
    key_n = 1'b1;
    tick(25);
    check("both_after_pin_stretch", {1'b0, resn}, 2'b00);
    tick(5);
    check("both_rel_edge30", {1'b0, resn}, 2'b00);
    tick(1);
    check("both_rel_edge31", {1'b0, resn}, 2'b01);
    check("both_cause_held", cause, 2'b11);

    // res during hold with key held, then key re-debounces.
    key_n = 1'b0;
    tick(15);
    check("hold_resn", {1'b0, resn}, 2'b00);
    check("hold_cause", cause, 2'b01);
    res = 1'b1;
    tick(1);
    check("res_mid_resn", {1'b0, resn}, 2'b00);
    check("res_mid_cause", cause, 2'b00);
    res = 1'b0;
    tick(10);
    check("redeb_edge10_cause", cause, 2'b00);
    check("redeb_edge10_resn", {1'b0, resn}, 2'b00);
    tick(1);
    check("redeb_edge11_cause", cause, 2'b01);
    key_n = 1'b1;
    tick(30);
    check("redeb_rel_edge30", {1'b0, resn}, 2'b00);
    tick(1);
    check("redeb_rel_edge31", {1'b0, resn}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
